// File: rtl/row_window_buffer.sv
// row_window_buffer
//   Multi-row line buffer for the ORB front end. Takes a raster pixel stream
//   and, for every accepted pixel, presents a vertical column of N_ROWS
//   pixels at the same x. Lane N_ROWS-1 is the pixel just accepted, and
//   lane 0 is the pixel N_ROWS-1 lines above it. The column is tagged with
//   the x/y of the newest lane, a window-valid flag and an end-of-frame pulse.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   ena        pixel valid; nothing advances unless ena=1
//   sof        start of frame, qualified by ena; forces the pixel to (0,0)
//   pixel      input pixel
//   col_out    lane k = [k*PIXEL_WIDTH +: PIXEL_WIDTH]; lane 0 = oldest row
//   col_valid  every lane of col_out belongs to the current frame
//   x_out      x of the newest lane
//   y_out      y of the newest lane
//   eof        one-cycle pulse when the newest lane is the last pixel of the frame
//
// Handshake: ena is a valid-only strobe. There is no ready and no
// back-pressure, so a pixel is accepted on every rising edge where ena=1
// and rst=0. All outputs change only on accepts, except eof, which clears
// on any non-accept edge.
module row_window_buffer #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int N_ROWS      = 37,
    parameter int XW          = 10,
    parameter int YW          = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          sof,
    input  logic [PIXEL_WIDTH-1:0]        pixel,
    output logic [N_ROWS*PIXEL_WIDTH-1:0] col_out,
    output logic                          col_valid,
    output logic [XW-1:0]                 x_out,
    output logic [YW-1:0]                 y_out,
    output logic                          eof
);

    localparam int              PW          = PIXEL_WIDTH;
    localparam int              DW          = (N_ROWS - 1) * PW;
    localparam logic [XW-1:0]   X_LAST      = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0]   Y_LAST      = YW'(IMG_HEIGHT - 1);
    localparam logic [YW-1:0]   Y_FULL_COL  = YW'(N_ROWS - 1);

    // Position the next pixel would get without sof.
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;

    // Position of the pixel on the input this cycle (sof overrides the counters).
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic [XW-1:0] nxt_x;
    logic [YW-1:0] nxt_y;

    // Line store j feeds lane j. All stores share one pointer equal to x.
    logic [PW-1:0] line_mem [N_ROWS-1][IMG_WIDTH];

    logic [DW-1:0]           rd_col;
    logic [N_ROWS*PW-1:0]    col_next;
    logic [DW-1:0]           wr_col;

    logic accept;

    assign accept = ena;

    always_comb begin
        cur_x = x_cnt;
        cur_y = y_cnt;
        if (sof) begin
            cur_x = '0;
            cur_y = '0;
        end
    end

    always_comb begin
        nxt_x = cur_x + 1'b1;
        nxt_y = cur_y;
        if (cur_x >= X_LAST) begin
            nxt_x = '0;
            nxt_y = (cur_y >= Y_LAST) ? '0 : cur_y + 1'b1;
        end
    end

    // Read-before-write: every store is read at the current x, and the
    // column shifts down by one lane on the way back into the stores.
    always_comb begin
        rd_col = '0;
        for (int j = 0; j < N_ROWS - 1; j++) begin
            rd_col[j*PW +: PW] = line_mem[j][cur_x];
        end
    end

    // The new column is {pixel, stored lanes}. Dropping lane 0 gives the
    // values each store keeps for the next line.
    assign col_next = {pixel, rd_col};
    assign wr_col   = col_next[N_ROWS*PW-1:PW];

    // The memory is not reset. A simultaneous rst blocks the write.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            for (int j = 0; j < N_ROWS - 1; j++) begin
                line_mem[j][cur_x] <= wr_col[j*PW +: PW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            col_out   <= '0;
            col_valid <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            eof       <= 1'b0;
        end else if (accept) begin
            x_cnt     <= nxt_x;
            y_cnt     <= nxt_y;
            col_out   <= col_next;
            col_valid <= (cur_y >= Y_FULL_COL);
            x_out     <= cur_x;
            y_out     <= cur_y;
            eof       <= (cur_x == X_LAST) && (cur_y == Y_LAST);
        end else begin
            eof       <= 1'b0;
        end
    end

endmodule
